conv_monitor: RTL

- Convergence monitor for the 4D gradient-descent datapath, sitting after the capped Q8.8 update stage (next = prev - step).
- Runs the update in reverse: for each dimension it recovers the applied step from the value pair, step = x_prev - x_next, computed at 17 bits and capped to Q8.8.
- Over successive 4-beat iterations it tracks the largest absolute step and counts iterations.
- Declares convergence when the largest step stays below a threshold for STABLE_ITERS consecutive iterations; declares timeout at MAX_ITERS.

---
 rtl/conv_monitor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/conv_monitor.sv
// Convergence monitor for the 4D gradient-descent update stage: recovers |prev - next| per beat,
// tracks the per-iteration maximum and stops on convergence or timeout. Optional: CONV_MONITOR_SAT_FLAG_EN.
module conv_monitor #(
  parameter int NUM_DIMS     = 4,
  parameter int STABLE_ITERS = 3,
  parameter int MAX_ITERS    = 1024,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      threshold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      x_prev,
  input  logic [15:0]      x_next,
  output logic             done,
  output logic             converged,
  output logic             timeout,
  output logic [15:0]      max_step,
  output logic [CNT_W-1:0] iter_count
`ifdef CONV_MONITOR_SAT_FLAG_EN
  ,
  output logic             step_sat
`endif
);

  localparam int BEAT_W = (NUM_DIMS > 1) ? $clog2(NUM_DIMS) : 1;
  localparam int STB_W  = $clog2(STABLE_ITERS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(NUM_DIMS - 1);
  localparam logic [STB_W-1:0]  STABLE_LIM = STB_W'(STABLE_ITERS);
  localparam logic [CNT_W-1:0]  ITER_LIM   = CNT_W'(MAX_ITERS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [BEAT_W-1:0]   beat_cnt;
  logic [STB_W-1:0]    stable_cnt;
  logic [15:0]         thr_q;
  logic [15:0]         run_max;
  logic signed [16:0]  diff;
  logic [16:0]         step_mag;
  logic [15:0]         step_cap;
  logic [15:0]         iter_max;
  logic                xfer, iter_end, sub_thr, conv_hit, to_hit;

  function automatic logic [16:0] abs17(input logic signed [16:0] v);
    abs17 = v[16] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // The upstream update stage can only apply Q8.8 steps up to 0x7FFF.
  function automatic logic [15:0] cap_step(input logic [16:0] mag);
    cap_step = (mag > 17'h07FFF) ? 16'h7FFF : mag[15:0];
  endfunction

  assign diff     = $signed({x_prev[15], x_prev}) - $signed({x_next[15], x_next});
  assign step_mag = abs17(diff);
  assign step_cap = cap_step(step_mag);
  assign iter_max = (beat_cnt == '0 || step_cap > run_max) ? step_cap : run_max;
  assign xfer     = in_valid && in_ready && !start;
  assign iter_end = xfer && (beat_cnt == LAST_BEAT);
  assign sub_thr  = iter_max < thr_q;
  assign conv_hit = iter_end && sub_thr && (stable_cnt + STB_W'(1) == STABLE_LIM);
  assign to_hit   = iter_end && (iter_count + CNT_W'(1) == ITER_LIM) && !conv_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start)                                      state_d = RUN;
    else if (state_q == RUN && (conv_hit || to_hit)) state_d = DONE;
  end

  always_comb begin
    in_ready = (state_q == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt   <= '0;
      stable_cnt <= '0;
      iter_count <= '0;
      max_step   <= '0;
      done       <= 1'b0;
      converged  <= 1'b0;
      timeout    <= 1'b0;
    end else if (start) begin
      beat_cnt   <= '0;
      stable_cnt <= '0;
      iter_count <= '0;
      max_step   <= '0;
      done       <= 1'b0;
      converged  <= 1'b0;
      timeout    <= 1'b0;
    end else if (xfer) begin
      beat_cnt <= iter_end ? '0 : beat_cnt + BEAT_W'(1);
      if (iter_end) begin
        max_step   <= iter_max;
        iter_count <= iter_count + CNT_W'(1);
        stable_cnt <= sub_thr ? stable_cnt + STB_W'(1) : '0;
        converged  <= conv_hit;
        timeout    <= to_hit;
        done       <= conv_hit || to_hit;
      end
    end
  end

  // Datapath registers carry no reset; start and the first beat of each iteration reload them.
  always_ff @(posedge clk) begin
    if (start) thr_q <= threshold;
    if (xfer)  run_max <= iter_max;
  end

`ifdef CONV_MONITOR_SAT_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          step_sat <= 1'b0;
    else if (start)                      step_sat <= 1'b0;
    else if (xfer && step_mag > 17'h07FFF) step_sat <= 1'b1;
  end
`endif

endmodule
